next_pc_unit: RTL

NEXT_PC_UNIT -- requirements
Module: next_pc_unit

---
 rtl/cpu_pkg.sv | 17 +
 rtl/ras_stack.sv | 53 +++++
 rtl/next_pc_unit.sv | 99 +++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default address/stack sizes and the next-PC
// source select encoding used by the fetch stage.
package cpu_pkg;

  localparam int AW_DEF        = 6;
  localparam int RAS_DEPTH_DEF = 4;

  typedef enum logic [2:0] {
    SEL_HOLD,
    SEL_SEQ,
    SEL_BR,
    SEL_JMP,
    SEL_CALL,
    SEL_RET
  } next_pc_sel_e;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: once full, a push silently overwrites the
// oldest entry while depth saturates at DEPTH.
module ras_stack
  import cpu_pkg::*;
#(
  parameter int DEPTH = RAS_DEPTH_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [AW-1:0]            push_data,
  output logic [AW-1:0]            top,
  output logic [$clog2(DEPTH):0]   depth,
  output logic                     full,
  output logic                     empty
);

  localparam int             PW       = $clog2(DEPTH);
  localparam logic [PW:0]    FULL_CNT = (PW+1)'(DEPTH);
  localparam logic [PW-1:0]  PTR_ONE  = PW'(1);

  logic [AW-1:0] entries [DEPTH];
  logic [PW-1:0] ptr;
  logic [PW-1:0] top_idx;

  // ptr names the next free slot; it wraps naturally because DEPTH is a power of two
  assign top_idx = ptr - PTR_ONE;
  assign top     = entries[top_idx];
  assign full    = (depth == FULL_CNT);
  assign empty   = (depth == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr   <= '0;
      depth <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else if (push) begin
      entries[ptr] <= push_data;
      ptr          <= ptr + PTR_ONE;
      if (!full) begin
        depth <= depth + 1'b1;
      end
    end else if (pop && !empty) begin
      ptr   <= top_idx;
      depth <= depth - 1'b1;
    end
  end

endmodule

// File: rtl/next_pc_unit.sv
// Next-PC selection: prioritised control decode, address adders and a
// return-address stack with sticky overflow/underflow flags.
module next_pc_unit
  import cpu_pkg::*;
#(
  parameter int RAS_DEPTH = RAS_DEPTH_DEF,
  parameter int AW        = AW_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [AW-1:0]               pc_in,
  input  logic                        stall,
  input  logic                        ret,
  input  logic                        call,
  input  logic                        jump,
  input  logic                        branch_taken,
  input  logic [AW-1:0]               imm,
  output logic [AW-1:0]               target,
  output logic [$clog2(RAS_DEPTH):0]  ras_depth,
  output logic                        ras_full,
  output logic                        ras_empty,
  output logic                        ras_ovf,
  output logic                        ras_unf
);

  localparam logic [AW-1:0] ONE = AW'(1);

  next_pc_sel_e  sel;
  logic [AW-1:0] pc_inc;
  logic [AW-1:0] pc_br;
  logic [AW-1:0] ras_top;
  logic          push;
  logic          pop;

  // Two's-complement offset add wraps modulo 2^AW, which is the sign extension we need
  assign pc_inc = pc_in + ONE;
  assign pc_br  = pc_in + imm;

  always_comb begin
    sel = SEL_SEQ;
    if (stall) begin
      sel = SEL_HOLD;
    end else if (ret) begin
      sel = SEL_RET;
    end else if (call) begin
      sel = SEL_CALL;
    end else if (jump) begin
      sel = SEL_JMP;
    end else if (branch_taken) begin
      sel = SEL_BR;
    end
  end

  always_comb begin
    target = pc_inc;
    unique case (sel)
      SEL_HOLD: target = pc_in;
      SEL_SEQ:  target = pc_inc;
      SEL_BR:   target = pc_br;
      SEL_JMP:  target = imm;
      SEL_CALL: target = imm;
      SEL_RET:  target = ras_empty ? pc_inc : ras_top;
      default:  target = pc_inc;
    endcase
  end

  assign push = (sel == SEL_CALL);
  assign pop  = (sel == SEL_RET) && !ras_empty;

  ras_stack #(
    .DEPTH (RAS_DEPTH),
    .AW    (AW)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc),
    .top       (ras_top),
    .depth     (ras_depth),
    .full      (ras_full),
    .empty     (ras_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ras_ovf <= 1'b0;
      ras_unf <= 1'b0;
    end else begin
      if (push && ras_full) begin
        ras_ovf <= 1'b1;
      end
      if ((sel == SEL_RET) && ras_empty) begin
        ras_unf <= 1'b1;
      end
    end
  end

endmodule
